// File: rtl/reg_pkg.sv
// Shared constants and the dump state encoding for the register file with
// sequential readout.
package reg_pkg;

  localparam int REG_WIDTH_DEFAULT  = 16;
  localparam int REG_ADDR_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_dump_fsm.sv
// Dump sequencer: walks idx over every register, capturing one value per
// beat (LOAD) and holding it on a valid/ready interface (SEND) until the
// sink accepts it. Pulses dump_done after the last beat is accepted.
module reg_dump_fsm
  import reg_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH_DEFAULT,
  parameter int ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [WIDTH-1:0]  load_data,
  output logic [ADDR_W-1:0] idx,
  output logic              dump_valid,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;

  // Next-state and next-output computation; all outputs are registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (dump_start) begin
          state_d = LOAD;
          idx_d   = {ADDR_W{1'b0}};
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      LOAD: begin
        // Captured value is frozen here; later writes cannot disturb it.
        addr_d  = idx_q;
        data_d  = load_data;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && dump_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = LOAD;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {ADDR_W{1'b0}};
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and output registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign idx        = idx_q;
  assign dump_valid = valid_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;

endmodule

// File: rtl/reg_file_dump.sv
// Register file with one write port, two combinational read ports and a
// sequential dump interface. Optional feature macro REG_FILE_DUMP_BYPASS_EN
// forwards a same-cycle write to the read ports and the dump capture.
module reg_file_dump
  import reg_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH_DEFAULT,
  parameter int ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [WIDTH-1:0]  reg_q [NUM_REGS];
  logic [WIDTH-1:0]  reg_d [NUM_REGS];
  logic [ADDR_W-1:0] idx_s;
  logic [WIDTH-1:0]  load_data_s;

  // Next register contents: only the addressed register takes a write.
  always_comb begin
    reg_d = reg_q;
    if (wr_en) begin
      reg_d[wr_addr] = wr_data;
    end else begin
      reg_d = reg_q;
    end
  end

  // Storage, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      reg_q <= reg_d;
    end
  end

  // Zero-latency read ports and the value offered to the dump capture.
  always_comb begin
`ifdef REG_FILE_DUMP_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = reg_q[rd_addr_a];
    end
    if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = reg_q[rd_addr_b];
    end
    if (wr_en && (wr_addr == idx_s)) begin
      load_data_s = wr_data;
    end else begin
      load_data_s = reg_q[idx_s];
    end
`else
    rd_data_a   = reg_q[rd_addr_a];
    rd_data_b   = reg_q[rd_addr_b];
    load_data_s = reg_q[idx_s];
`endif
  end

  reg_dump_fsm #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_dump_fsm (
    .clock     (clock),
    .reset     (reset),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .load_data (load_data_s),
    .idx       (idx_s),
    .dump_valid(dump_valid),
    .dump_busy (dump_busy),
    .dump_done (dump_done),
    .dump_addr (dump_addr),
    .dump_data (dump_data)
  );

endmodule

// File: tb/tb_reg_file_dump.sv
// Self-checking bench for reg_file_dump: random writes/reads against a
// register array model, dump beats checked by a scoreboard monitor.
module tb_reg_file_dump;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;
`ifdef REG_FILE_DUMP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a, rd_data_b;
  logic              dump_start, dump_valid, dump_ready, dump_busy, dump_done;
  logic [ADDR_W-1:0] dump_addr;
  logic [WIDTH-1:0]  dump_data;

  always #5 clock = ~clock;

  reg_file_dump #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_pulses = 0;
  logic [WIDTH-1:0] model [NREG];
  logic [ADDR_W+WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (BYPASS && wr_en && (wr_addr == a)) return wr_data;
    return model[a];
  endfunction

  // Scoreboard monitor: pops on each accepted beat, checks hold stability.
  logic              hold_pending = 1'b0;
  logic [ADDR_W-1:0] hold_addr;
  logic [WIDTH-1:0]  hold_data;
  always @(negedge clock) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (dump_done) done_pulses++;
      if (hold_pending) begin
        check("hold_valid", 32'(dump_valid), 32'd1);
        check("hold_addr", 32'(dump_addr), 32'(hold_addr));
        check("hold_data", 32'(dump_data), 32'(hold_data));
      end
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 32'(dump_addr), 32'hFFFF_FFFF);
        end else begin
          logic [ADDR_W+WIDTH-1:0] item;
          item = exp_q.pop_front();
          check("beat_addr", 32'(dump_addr), 32'(item[WIDTH +: ADDR_W]));
          check("beat_data", 32'(dump_data), 32'(item[WIDTH-1:0]));
        end
      end
      hold_pending = dump_valid && !dump_ready;
      hold_addr    = dump_addr;
      hold_data    = dump_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle_rw(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                          input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    @(negedge clock);
    check("rd_a", 32'(rd_data_a), 32'(exp_read(ra)));
    check("rd_b", 32'(rd_data_b), 32'(exp_read(rb)));
    @(posedge clock);
    if (we) model[wa] = wd;
    #1;
    wr_en = 1'b0;
  endtask

  task automatic push_all_beats();
    for (int i = 0; i < NREG; i++) exp_q.push_back({ADDR_W'(i), model[i]});
  endtask

  task automatic start_pulse();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic wait_beat(input int n, input bit rand_ready);
    for (int k = 0; k < 300; k++) begin
      if (dump_valid && (32'(dump_addr) == n)) return;
      if (rand_ready) dump_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("wait_beat_timeout", 32'd0, 32'(n));
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, output int cycles);
    cycles = -1;
    for (int k = 1; k <= budget; k++) begin
      if (rand_ready) dump_ready = 1'($urandom_range(0, 1));
      tick();
      if (dump_done) begin
        cycles = k;
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NREG; i++) begin
      rd_addr_a = ADDR_W'(i);
      rd_addr_b = ADDR_W'(NREG - 1 - i);
      #1;
      check(name, 32'(rd_data_a), 32'd0);
      check(name, 32'(rd_data_b), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [WIDTH-1:0] nv;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; dump_start = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    repeat (2) tick();
    // Reset state
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_busy", 32'(dump_busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    check("rst_addr", 32'(dump_addr), 32'd0);
    check("rst_data", 32'(dump_data), 32'd0);
    check_all_zero("rst_regs");
    reset = 1'b0;
    tick();

    // Random write/read traffic
    for (int n = 0; n < 40; n++)
      cycle_rw(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREG - 1)), WIDTH'($urandom),
               ADDR_W'($urandom_range(0, NREG - 1)), ADDR_W'($urandom_range(0, NREG - 1)));

    // Write 0x1234 to r3 while reading r3 in the same and the next cycle
    cycle_rw(1'b1, 3'd3, 16'h1234, 3'd3, 3'd3);
    cycle_rw(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0);

    // Load r0..r7 = 0x0100+i and dump with ready held high
    for (int i = 0; i < NREG; i++) cycle_rw(1'b1, ADDR_W'(i), 16'h0100 + WIDTH'(i), ADDR_W'(i), 3'd0);
    push_all_beats();
    done_pulses = 0;
    dump_ready = 1'b1;
    start_pulse();
    check("busy_after_start", 32'(dump_busy), 32'd1);
    wait_done(60, 1'b0, cyc);
    check("done_latency", 32'(cyc), 32'd16);
    tick();
    check("done_one_cycle", 32'(dump_done), 32'd0);
    check("busy_after_done", 32'(dump_busy), 32'd0);
    check("done_count1", 32'(done_pulses), 32'd1);
    check("beats_left1", 32'(exp_q.size()), 32'd0);

    // Backpressure at beat 2 with a write to r2, restart attempt at beat 4
    push_all_beats();
    done_pulses = 0;
    start_pulse();
    wait_beat(2, 1'b1);
    dump_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      wr_en = (h == 0); wr_addr = 3'd2; wr_data = 16'hBEEF; rd_addr_a = 3'd2;
      tick();
      if (h == 0) model[2] = 16'hBEEF;
      wr_en = 1'b0;
      #1;
      check("bp_data", 32'(dump_data), 32'h0102);
      check("bp_valid", 32'(dump_valid), 32'd1);
      check("bp_rd_r2", 32'(rd_data_a), 32'hBEEF);
    end
    dump_ready = 1'b1;
    wait_beat(4, 1'b1);
    start_pulse();
    wait_done(300, 1'b1, cyc);
    check("done_seen2", 32'(cyc > 0), 32'd1);
    dump_ready = 1'b1;
    repeat (4) tick();
    check("done_count2", 32'(done_pulses), 32'd1);
    check("beats_left2", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of beat 5
    push_all_beats();
    done_pulses = 0;
    start_pulse();
    wait_beat(5, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(dump_valid), 32'd0);
    check("mid_rst_busy", 32'(dump_busy), 32'd0);
    check("mid_rst_addr", 32'(dump_addr), 32'd0);
    check("mid_rst_data", 32'(dump_data), 32'd0);
    exp_q.delete();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    check_all_zero("mid_rst_regs");
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5A5A; dump_start = 1'b1;
    tick();
    wr_en = 1'b0; dump_start = 1'b0;
    tick();
    reset = 1'b0;
    check_all_zero("post_rst_regs");
    check("post_rst_busy", 32'(dump_busy), 32'd0);
    repeat (20) tick();
    check("post_rst_no_done", 32'(done_pulses), 32'd0);
    check("post_rst_idle", 32'(dump_valid), 32'd0);

    // Write r7 in the LOAD cycle of index 7
    for (int i = 0; i < NREG; i++)
      cycle_rw(1'b1, ADDR_W'(i), WIDTH'($urandom), ADDR_W'(i), ADDR_W'(NREG - 1 - i));
    nv = model[7] ^ 16'hA5A5;
    for (int i = 0; i < NREG - 1; i++) exp_q.push_back({ADDR_W'(i), model[i]});
    exp_q.push_back({3'd7, BYPASS ? nv : model[7]});
    done_pulses = 0;
    dump_ready = 1'b1;
    start_pulse();
    wait_beat(6, 1'b0);
    tick();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = nv;
    tick();
    wr_en = 1'b0;
    model[7] = nv;
    wait_done(40, 1'b0, cyc);
    check("done_seen4", 32'(cyc > 0), 32'd1);
    tick();
    check("done_count4", 32'(done_pulses), 32'd1);
    check("beats_left4", 32'(exp_q.size()), 32'd0);
    cycle_rw(1'b0, 3'd0, 16'h0000, 3'd7, 3'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
